// File: rtl/ddr3_pkg.sv
// ddr3_pkg: shared definitions for the DDR3 port arbiter.
//   state_t           - arbiter FSM encoding (IDLE/BUSY/RESP)
//   DDR3_ARB_ERR_DATA - read data returned to a master when the downstream
//                       ack watchdog expires (DDR3_ARB_TIMEOUT_EN builds)
package ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DDR3_ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ddr3_port_arb_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   in  N_PORTS  active request per port
//   ptr   in  IDX_W    last granted port; search starts at ptr+1 (wrapping)
//   grant out IDX_W    chosen port (0 when nothing is requested)
//   valid out 1        at least one request is active
module rr_pick #(
  parameter int N_PORTS = 2,
  parameter int IDX_W   = 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);

  // One extra bit so ptr + offset never overflows before the wrap.
  logic [IDX_W:0]   sum_next;
  logic [IDX_W-1:0] cand_next;

  // Walk offsets from farthest to nearest so the nearest active port
  // after ptr overrides every later one.
  always_comb begin
    grant     = '0;
    valid     = 1'b0;
    sum_next  = '0;
    cand_next = '0;
    for (int off = N_PORTS; off >= 1; off--) begin
      sum_next = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum_next >= (IDX_W+1)'(N_PORTS)) begin
        sum_next = sum_next - (IDX_W+1)'(N_PORTS);
      end
      cand_next = sum_next[IDX_W-1:0];
      if (req[cand_next]) begin
        grant = cand_next;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_port_arb.sv
// ddr3_port_arb: N-port round-robin front end for a single DDR3 port.
// Serialises one transaction at a time (IDLE -> BUSY -> RESP), routes read
// data and a one-cycle ack back to the winning master.
// Optional feature macro: DDR3_ARB_TIMEOUT_EN enables the downstream ack
// watchdog (TIMEOUT cycles) and the err_o pulse; otherwise err_o is 0.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr_i/data_i       per-port address / write data, port k at [k*W +: W]
//   we_i/rd_i           per-port level requests, held until ack_o
//   data_o              per-port registered read data (keeps last read)
//   ack_o               per-port one-cycle completion pulse
//   mem_*               downstream port (addr, wdata, rdata, we, rd, ack)
//   err_o               one-cycle watchdog timeout pulse
//   state_value         debug {5'b0, grant[2:0], 6'b0, state[1:0]}
module ddr3_port_arb
  import ddr3_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [N_PORTS*DATA_W-1:0]   data_i,
  output logic [N_PORTS*DATA_W-1:0]   data_o,
  input  logic [N_PORTS-1:0]          we_i,
  input  logic [N_PORTS-1:0]          rd_i,
  output logic [N_PORTS-1:0]          ack_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_data_o,
  input  logic [DATA_W-1:0]           mem_data_i,
  output logic                        mem_we_o,
  output logic                        mem_rd_o,
  input  logic                        mem_ack_i,
  output logic                        err_o,
  output logic [15:0]                 state_value
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  state_t             state_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [N_PORTS-1:0] req_next;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [ADDR_W-1:0]  addr_arr [N_PORTS];
  logic [DATA_W-1:0]  wdata_arr [N_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign req_next[gi]  = we_i[gi] | rd_i[gi];
      assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (req_next),
    .ptr   (rr_ptr_reg),
    .grant (pick_idx),
    .valid (pick_valid)
  );

`ifdef DDR3_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_reg;
`endif

  // mem_addr_o / mem_data_o / mem_we_o double as the latched transaction:
  // they are loaded at grant and stay put until the next grant, so master
  // changes during BUSY cannot leak through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= IDX_W'(N_PORTS - 1);
      mem_addr_o <= '0;
      mem_data_o <= '0;
      mem_we_o   <= 1'b0;
      mem_rd_o   <= 1'b0;
      ack_o      <= '0;
      data_o     <= '0;
`ifdef DDR3_ARB_TIMEOUT_EN
      wd_reg     <= '0;
      err_o      <= 1'b0;
`endif
    end else begin
      ack_o <= '0;
`ifdef DDR3_ARB_TIMEOUT_EN
      err_o <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_reg  <= pick_idx;
            rr_ptr_reg <= pick_idx;
            mem_addr_o <= addr_arr[pick_idx];
            mem_data_o <= wdata_arr[pick_idx];
            // Write wins when both are requested.
            mem_we_o   <= we_i[pick_idx];
            mem_rd_o   <= ~we_i[pick_idx];
`ifdef DDR3_ARB_TIMEOUT_EN
            wd_reg     <= '0;
`endif
            state_reg  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A real ack beats a same-cycle watchdog expiry.
          if (mem_ack_i) begin
            mem_we_o <= 1'b0;
            mem_rd_o <= 1'b0;
            if (!mem_we_o) begin
              data_o[grant_reg*DATA_W +: DATA_W] <= mem_data_i;
            end
            ack_o[grant_reg] <= 1'b1;
            state_reg        <= ST_RESP;
          end
`ifdef DDR3_ARB_TIMEOUT_EN
          else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
            mem_we_o <= 1'b0;
            mem_rd_o <= 1'b0;
            if (!mem_we_o) begin
              data_o[grant_reg*DATA_W +: DATA_W] <= DATA_W'(DDR3_ARB_ERR_DATA);
            end
            ack_o[grant_reg] <= 1'b1;
            err_o            <= 1'b1;
            state_reg        <= ST_RESP;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          // Dead cycle lets the master drop its request before re-arbitration.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef DDR3_ARB_TIMEOUT_EN
  assign err_o = 1'b0;
`endif

  assign state_value = {5'b0, 3'(grant_reg), 6'b0, state_reg};

endmodule

// File: tb/tb_ddr3_port_arb.sv
// tb_ddr3_port_arb: directed self-checking bench for ddr3_port_arb
// (N_PORTS=2, 32-bit address/data, TIMEOUT=16).
module tb_ddr3_port_arb;

  localparam int NP = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*32-1:0] addr_i;
  logic [NP*32-1:0] data_i;
  logic [NP*32-1:0] data_o;
  logic [NP-1:0]  we_i;
  logic [NP-1:0]  rd_i;
  logic [NP-1:0]  ack_o;
  logic [31:0]    mem_addr_o;
  logic [31:0]    mem_data_o;
  logic [31:0]    mem_data_i;
  logic           mem_we_o;
  logic           mem_rd_o;
  logic           mem_ack_i;
  logic           err_o;
  logic [15:0]    state_value;

  int chk_cnt = 0;
  int err_cnt = 0;

  logic [31:0] dout0;
  logic [31:0] dout1;
  assign dout0 = data_o[31:0];
  assign dout1 = data_o[63:32];

  always #5 clk = ~clk;

  ddr3_port_arb #(
    .N_PORTS (NP),
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .we_i        (we_i),
    .rd_i        (rd_i),
    .ack_o       (ack_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_we_o    (mem_we_o),
    .mem_rd_o    (mem_rd_o),
    .mem_ack_i   (mem_ack_i),
    .err_o       (err_o),
    .state_value (state_value)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    addr_i     = '0;
    data_i     = '0;
    we_i       = '0;
    rd_i       = '0;
    mem_data_i = '0;
    mem_ack_i  = 1'b0;
    do_reset();

    // Reset state
    check("rst_state", 64'(state_value), 64'h0);
    check("rst_mem_rd", 64'(mem_rd_o), 64'h0);
    check("rst_ack", 64'(ack_o), 64'h0);
    check("rst_data_o", 64'(data_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);

    // 1: single read on port 0, ack after 4 busy cycles
    rd_i[0]       = 1'b1;
    addr_i[31:0]  = 32'h100;
    tick();
    check("t1_rd_rise", 64'(mem_rd_o), 64'h1);
    check("t1_addr", 64'(mem_addr_o), 64'h100);
    check("t1_state", 64'(state_value), 64'h0001);
    tick();
    tick();
    tick();
    check("t1_no_early_ack", 64'(ack_o), 64'h0);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h1234_5678;
    tick();
    mem_ack_i = 1'b0;
    check("t1_ack", 64'(ack_o), 64'h1);
    check("t1_rd_drop", 64'(mem_rd_o), 64'h0);
    check("t1_data", 64'(dout0), 64'h1234_5678);
    check("t1_resp", 64'(state_value), 64'h0002);
    rd_i = '0;
    tick();
    check("t1_ack_once", 64'(ack_o), 64'h0);
    check("t1_idle", 64'(state_value), 64'h0000);

    // 2: both ports request continuously, immediate ack -> 0,1,0,1
    do_reset();
    rd_i      = 2'b11;
    mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_data_i = 32'hC0DE_0000 + 32'(i);
      tick();
      check($sformatf("t2_grant%0d", i), 64'(state_value), (i % 2 == 0) ? 64'h0001 : 64'h0101);
      tick();
      check($sformatf("t2_ack%0d", i), 64'(ack_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    check("t2_data0", 64'(dout0), 64'hC0DE_0002);
    check("t2_data1", 64'(dout1), 64'hC0DE_0003);
    rd_i      = '0;
    mem_ack_i = 1'b0;
    tick();

    // 3: write and read together on port 1 -> write wins
    we_i[1]        = 1'b1;
    rd_i[1]        = 1'b1;
    addr_i[63:32]  = 32'h200;
    data_i[63:32]  = 32'hA5A5_A5A5;
    tick();
    check("t3_we", 64'(mem_we_o), 64'h1);
    check("t3_rd", 64'(mem_rd_o), 64'h0);
    check("t3_wdata", 64'(mem_data_o), 64'hA5A5_A5A5);
    check("t3_state", 64'(state_value), 64'h0101);
    data_i[63:32] = 32'h0;
    addr_i[63:32] = 32'h0;
    tick();
    check("t3_latched_data", 64'(mem_data_o), 64'hA5A5_A5A5);
    check("t3_latched_addr", 64'(mem_addr_o), 64'h200);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'hFFFF_FFFF;
    tick();
    mem_ack_i = 1'b0;
    check("t3_ack", 64'(ack_o), 64'h2);
    check("t3_data_kept", 64'(dout1), 64'hC0DE_0003);
    we_i = '0;
    rd_i = '0;
    tick();

    // 4: reset during BUSY, then a stray ack
    rd_i = 2'b10;
    tick();
    check("t4_busy", 64'(mem_rd_o), 64'h1);
    rst = 1'b1;
    tick();
    check("t4_rst_rd", 64'(mem_rd_o), 64'h0);
    check("t4_rst_state", 64'(state_value), 64'h0);
    check("t4_rst_data", 64'(data_o), 64'h0);
    rst       = 1'b0;
    rd_i      = '0;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    check("t4_stray_ack", 64'(ack_o), 64'h0);
    check("t4_stray_state", 64'(state_value), 64'h0);
    rd_i = 2'b11;
    tick();
    check("t4_next_port0", 64'(state_value), 64'h0001);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    rd_i      = '0;
    check("t4_ack", 64'(ack_o), 64'h1);
    tick();

    // 6: port 1 drops request mid-BUSY, still completes once
    rd_i = 2'b10;
    tick();
    rd_i = '0;
    tick();
    check("t6_still_busy", 64'(state_value), 64'h0101);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h600D_F00D;
    tick();
    mem_ack_i = 1'b0;
    check("t6_ack", 64'(ack_o), 64'h2);
    check("t6_data", 64'(dout1), 64'h600D_F00D);
    tick();
    check("t6_idle", 64'(state_value), 64'h0100);
    tick();
    check("t6_no_second", 64'(state_value), 64'h0100);
    check("t6_no_rd", 64'(mem_rd_o), 64'h0);

    // 5: read with no downstream ack
    rd_i = 2'b01;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    check("t5_busy_16", 64'(state_value), 64'h0001);
    check("t5_no_ack_yet", 64'(ack_o), 64'h0);
`ifdef DDR3_ARB_TIMEOUT_EN
    tick();
    check("t5_to_ack", 64'(ack_o), 64'h1);
    check("t5_to_err", 64'(err_o), 64'h1);
    check("t5_to_data", 64'(dout0), 64'hDEAD_BEEF);
    check("t5_to_rd_drop", 64'(mem_rd_o), 64'h0);
    rd_i = '0;
    tick();
    check("t5_err_pulse", 64'(err_o), 64'h0);
`else
    tick();
    check("t5_wait_forever", 64'(state_value), 64'h0001);
    check("t5_no_err", 64'(err_o), 64'h0);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h0BAD_CAFE;
    tick();
    mem_ack_i = 1'b0;
    rd_i      = '0;
    check("t5_late_ack", 64'(ack_o), 64'h1);
    check("t5_late_data", 64'(dout0), 64'h0BAD_CAFE);
    tick();
`endif
    // Next request is served normally
    rd_i = 2'b01;
    tick();
    check("t5_next_rd", 64'(mem_rd_o), 64'h1);
    mem_ack_i  = 1'b1;
    mem_data_i = 32'h7777_0001;
    tick();
    mem_ack_i = 1'b0;
    rd_i      = '0;
    check("t5_next_ack", 64'(ack_o), 64'h1);
    check("t5_next_data", 64'(dout0), 64'h7777_0001);
    check("t5_next_err", 64'(err_o), 64'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
